// File: rtl/imm_decode_pipe.sv
// imm_decode_pipe
//   Decodes the immediate field of a RISC-V instruction word at acceptance time
//   and queues {imm, fmt, illegal} in a 2-entry FIFO. All result outputs are
//   taken from the FIFO head. Two saturating counters track popped results.
//
// Parameters
//   XLEN   output datapath width (32 or 64)
//   CNT_W  statistics counter width
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   flush        synchronous FIFO clear (counters untouched)
//   in_valid     instruction word offered
//   in_ready     word can be accepted this cycle (not full, out of reset)
//   in_instr     raw 32-bit instruction word
//   out_valid    FIFO head holds a result
//   out_ready    consumer takes the head this cycle
//   out_imm      sign-extended immediate
//   out_fmt      0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J
//   out_illegal  opcode not recognised for this XLEN
//   cnt_decoded  popped results, saturating
//   cnt_illegal  popped illegal results, saturating
module imm_decode_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] cnt_decoded,
  output logic [CNT_W-1:0] cnt_illegal
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  localparam bit IS64 = (XLEN == 64);

  logic [31:0]      imm32_s;
  logic [XLEN-1:0]  dec_imm_s;
  logic [2:0]       dec_fmt_s;
  logic             dec_ill_s;

  logic [XLEN-1:0]  imm_mem_r [0:1];
  logic [2:0]       fmt_mem_r [0:1];
  logic             ill_mem_r [0:1];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;
  logic             init_r;
  logic [CNT_W-1:0] cnt_dec_r;
  logic [CNT_W-1:0] cnt_ill_r;

  logic             push_s;
  logic             pop_s;

  // in_ready is held low until the first clock edge after reset releases.
  assign in_ready    = init_r & (count_r != 2'd2);
  assign out_valid   = (count_r != 2'd0);
  assign out_imm     = imm_mem_r[rd_ptr_r];
  assign out_fmt     = fmt_mem_r[rd_ptr_r];
  assign out_illegal = ill_mem_r[rd_ptr_r];
  assign cnt_decoded = cnt_dec_r;
  assign cnt_illegal = cnt_ill_r;

  // Flush suppresses both the push and the pop of the same cycle.
  assign push_s = in_valid & in_ready & ~flush;
  assign pop_s  = out_valid & out_ready & ~flush;

  // Opcode decode to a 32-bit sign-extended immediate, format and legality.
  always_comb begin
    imm32_s   = 32'd0;
    dec_fmt_s = FMT_NONE;
    dec_ill_s = 1'b0;
    case (in_instr[6:0])
      7'b0000011, 7'b0001111, 7'b1100111, 7'b1110011, 7'b0010011: begin
        dec_fmt_s = FMT_I;
        imm32_s   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0011011: begin
        // OP-IMM-32 only exists on RV64.
        if (IS64) begin
          dec_fmt_s = FMT_I;
          imm32_s   = {{20{in_instr[31]}}, in_instr[31:20]};
        end else begin
          dec_ill_s = 1'b1;
        end
      end
      7'b0100011: begin
        dec_fmt_s = FMT_S;
        imm32_s   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt_s = FMT_B;
        imm32_s   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b1101111: begin
        dec_fmt_s = FMT_J;
        imm32_s   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt_s = FMT_U;
        imm32_s   = {in_instr[31:12], 12'd0};
      end
      7'b0110011: begin
        dec_fmt_s = FMT_NONE;
      end
      7'b0111011: begin
        // OP-32 only exists on RV64.
        if (IS64) begin
          dec_ill_s = 1'b0;
        end else begin
          dec_ill_s = 1'b1;
        end
      end
      default: begin
        dec_ill_s = 1'b1;
      end
    endcase
  end

  // Widen the 32-bit immediate to XLEN by replicating bit 31.
  always_comb begin
    dec_imm_s       = {XLEN{1'b0}};
    dec_imm_s[31:0] = imm32_s;
    for (int i = 32; i < XLEN; i++) begin
      dec_imm_s[i] = imm32_s[31];
    end
  end

  // Tracks the first clock edge after reset so in_ready rises only then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_r <= 1'b0;
    end else begin
      init_r <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; flush empties the queue in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else if (flush) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ~wr_ptr_r;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; cleared on reset so the head reads zero while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        imm_mem_r[i] <= {XLEN{1'b0}};
        fmt_mem_r[i] <= FMT_NONE;
        ill_mem_r[i] <= 1'b0;
      end
    end else if (push_s) begin
      imm_mem_r[wr_ptr_r] <= dec_imm_s;
      fmt_mem_r[wr_ptr_r] <= dec_fmt_s;
      ill_mem_r[wr_ptr_r] <= dec_ill_s;
    end else begin
      imm_mem_r[wr_ptr_r] <= imm_mem_r[wr_ptr_r];
    end
  end

  // Saturating statistics counters, advanced only by real pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_dec_r <= {CNT_W{1'b0}};
      cnt_ill_r <= {CNT_W{1'b0}};
    end else if (pop_s) begin
      if (cnt_dec_r != {CNT_W{1'b1}}) begin
        cnt_dec_r <= cnt_dec_r + CNT_W'(1);
      end else begin
        cnt_dec_r <= cnt_dec_r;
      end
      if (ill_mem_r[rd_ptr_r] && (cnt_ill_r != {CNT_W{1'b1}})) begin
        cnt_ill_r <= cnt_ill_r + CNT_W'(1);
      end else begin
        cnt_ill_r <= cnt_ill_r;
      end
    end else begin
      cnt_dec_r <= cnt_dec_r;
      cnt_ill_r <= cnt_ill_r;
    end
  end

endmodule

// File: tb/tb_imm_decode_pipe.sv
module tb_imm_decode_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = 32'd0;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_imm;
  logic [2:0]  a_out_fmt;
  logic [15:0] a_cnt_dec, a_cnt_ill;

  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [63:0] b_out_imm;
  logic [2:0]  b_out_fmt;
  logic [15:0] b_cnt_dec, b_cnt_ill;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imm_decode_pipe #(.XLEN(32), .CNT_W(16)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_illegal(a_out_illegal),
    .cnt_decoded(a_cnt_dec), .cnt_illegal(a_cnt_ill)
  );

  imm_decode_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_illegal(b_out_illegal),
    .cnt_decoded(b_cnt_dec), .cnt_illegal(b_cnt_ill)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        ill32;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ill64;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    tick;
    rst = 1'b0;
    tick;
  endtask

  function automatic logic [31:0] addi_word(input int v);
    logic [11:0] im;
    im = 12'(v);
    return {im, 20'h00093};
  endfunction

  initial begin
    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    vecs[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0};
    vecs[2]  = '{32'h0040006F, 32'h00000004, 3'd5, 1'b0, 64'h0000000000000004, 3'd5, 1'b0};
    vecs[3]  = '{32'h80000037, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
    vecs[4]  = '{32'h0010009B, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000001, 3'd1, 1'b0};
    vecs[5]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0};
    vecs[6]  = '{32'h002081B3, 32'h00000000, 3'd0, 1'b0, 64'h0000000000000000, 3'd0, 1'b0};
    vecs[7]  = '{32'h0000003B, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b0};
    vecs[8]  = '{32'h0000007F, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1};
    vecs[9]  = '{32'h12345017, 32'h12345000, 3'd4, 1'b0, 64'h0000000012345000, 3'd4, 1'b0};
    vecs[10] = '{32'h7FF02003, 32'h000007FF, 3'd1, 1'b0, 64'h00000000000007FF, 3'd1, 1'b0};
    vecs[11] = '{32'h800000E7, 32'hFFFFF800, 3'd1, 1'b0, 64'hFFFFFFFFFFFFF800, 3'd1, 1'b0};
    vecs[12] = '{32'h00000463, 32'h00000008, 3'd3, 1'b0, 64'h0000000000000008, 3'd3, 1'b0};
    vecs[13] = '{32'h00000073, 32'h00000000, 3'd1, 1'b0, 64'h0000000000000000, 3'd1, 1'b0};
    vecs[14] = '{32'h0FF0000F, 32'h000000FF, 3'd1, 1'b0, 64'h00000000000000FF, 3'd1, 1'b0};
    vecs[15] = '{32'hFFDFF0EF, 32'hFFFFFFFC, 3'd5, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0};

    // Reset state while rst is held high.
    tick;
    chk("reset_x32", {a_in_ready, a_out_valid, a_out_imm, a_out_fmt, a_out_illegal, a_cnt_dec, a_cnt_ill}, 128'd0);
    chk("reset_x64", {b_in_ready, b_out_valid, b_out_imm, b_out_fmt, b_out_illegal, b_cnt_dec, b_cnt_ill}, 128'd0);
    rst = 1'b0;
    tick;
    chk("ready_after_reset", {a_in_ready, b_in_ready, a_out_valid, b_out_valid}, {1'b1, 1'b1, 1'b0, 1'b0});

    // Table of single-word decodes: push, check head one cycle later, pop.
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      out_ready = 1'b0;
      tick;
      in_valid = 1'b0;
      chk($sformatf("vec%0d_x32", i), {a_out_valid, a_out_imm, a_out_fmt, a_out_illegal},
          {1'b1, vecs[i].imm32, vecs[i].fmt32, vecs[i].ill32});
      chk($sformatf("vec%0d_x64", i), {b_out_valid, b_out_imm, b_out_fmt, b_out_illegal},
          {1'b1, vecs[i].imm64, vecs[i].fmt64, vecs[i].ill64});
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
    end
    chk("table_cnt_x32", {a_out_valid, a_cnt_dec, a_cnt_ill}, {1'b0, 16'd16, 16'd3});
    chk("table_cnt_x64", {b_out_valid, b_cnt_dec, b_cnt_ill}, {1'b0, 16'd16, 16'd1});

    // Backpressure: three words offered, two accepted, head held.
    do_reset;
    in_valid = 1'b1;
    in_instr = addi_word(1);
    tick;
    in_instr = addi_word(2);
    tick;
    in_instr = addi_word(3);
    chk("bp_full_ready", {a_in_ready, b_in_ready}, {1'b0, 1'b0});
    tick;
    chk("bp_head_stable", {a_in_ready, a_out_valid, a_out_imm}, {1'b0, 1'b1, 32'd1});
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("bp_second", {a_out_valid, a_out_imm, a_cnt_dec}, {1'b1, 32'd2, 16'd1});
    tick;
    chk("bp_drained", {a_out_valid, a_cnt_dec}, {1'b0, 16'd2});
    in_valid = 1'b1;
    in_instr = addi_word(3);
    out_ready = 1'b0;
    tick;
    chk("bp_third", {a_out_valid, a_out_imm}, {1'b1, 32'd3});
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("bp_cnt3", {a_out_valid, a_cnt_dec, b_cnt_dec}, {1'b0, 16'd3, 16'd3});

    // Streaming push and pop at occupancy 1.
    do_reset;
    in_valid = 1'b1;
    in_instr = addi_word(100);
    tick;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_instr = addi_word(101 + i);
      out_ready = 1'b1;
      chk($sformatf("stream%0d", i), {a_in_ready, a_out_valid, a_out_imm},
          {1'b1, 1'b1, 32'(100 + i)});
      tick;
    end
    in_valid = 1'b0;
    chk("stream_last", {a_out_valid, a_out_imm, a_cnt_dec}, {1'b1, 32'd110, 16'd10});
    tick;
    chk("stream_done", {a_out_valid, a_cnt_dec}, {1'b0, 16'd11});

    // Flush with a full FIFO plus a same-cycle push and pop request.
    do_reset;
    in_valid = 1'b1;
    in_instr = 32'h0000007F;
    tick;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    in_valid = 1'b1;
    tick;
    tick;
    flush = 1'b1;
    out_ready = 1'b1;
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("flush_empty", {a_out_valid, a_in_ready, a_cnt_dec, a_cnt_ill}, {1'b0, 1'b1, 16'd1, 16'd1});
    tick;
    chk("flush_no_push", {a_out_valid, b_out_valid}, {1'b0, 1'b0});

    // Saturation: 65535 illegal pops, then one more.
    do_reset;
    in_valid = 1'b1;
    in_instr = 32'h0000007F;
    tick;
    out_ready = 1'b1;
    repeat (65535) tick;
    chk("sat_preload", {a_cnt_dec, a_cnt_ill, b_cnt_ill}, {16'hFFFF, 16'hFFFF, 16'hFFFF});
    in_valid = 1'b0;
    tick;
    chk("sat_hold", {a_out_valid, a_cnt_dec, a_cnt_ill}, {1'b0, 16'hFFFF, 16'hFFFF});
    out_ready = 1'b0;

    // Asynchronous reset in mid-cycle with a full FIFO.
    do_reset;
    in_valid = 1'b1;
    in_instr = addi_word(5);
    tick;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = addi_word(6);
    tick;
    in_instr = addi_word(7);
    tick;
    in_valid = 1'b0;
    chk("areset_pre", {a_in_ready, a_out_valid, a_cnt_dec}, {1'b0, 1'b1, 16'd1});
    #3;
    rst = 1'b1;
    #1;
    chk("areset_x32", {a_in_ready, a_out_valid, a_out_imm, a_out_fmt, a_cnt_dec, a_cnt_ill}, 128'd0);
    chk("areset_x64", {b_in_ready, b_out_valid, b_out_imm, b_cnt_dec, b_cnt_ill}, 128'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("areset_ready_low", {a_in_ready, b_in_ready}, {1'b0, 1'b0});
    tick;
    chk("areset_ready_high", {a_in_ready, a_out_valid}, {1'b1, 1'b0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
